// File: rtl/hex_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_mux
// Purpose  : Time-multiplexes up to four hex digits onto one shared 7-segment
//            decoder, with per-slot anode blanking and frame-aligned snapshots.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_mux #(
    parameter int NUM_DIGITS   = 2,
    parameter int DIGIT_CYCLES = 2400,
    parameter int BLANK_CYCLES = 200
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              s,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [1:0]              digit_idx,
    output logic                    frame_tick
);

    localparam int               C_CW       = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [C_CW-1:0]  C_CNT_LAST = C_CW'(DIGIT_CYCLES - 1);
    localparam logic [1:0]       C_IDX_LAST = 2'(NUM_DIGITS - 1);

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 4 || DIGIT_CYCLES < 2 ||
            BLANK_CYCLES < 0 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_param_check
            $error("hex_display_mux: illegal parameter combination");
        end
    endgenerate

    logic [C_CW-1:0]         cnt_q, cnt_d;
    logic [1:0]              idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    active_q, active_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_lit;

    assign w_slot_end  = (cnt_q == C_CNT_LAST);
    assign w_frame_end = w_slot_end && (idx_q == C_IDX_LAST);

    // The anode is lit only once the blanking window of the slot has elapsed.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign w_lit = 1'b1;
        end else begin : g_blank
            localparam logic [C_CW-1:0] C_BLANK = C_CW'(BLANK_CYCLES);
            assign w_lit = (cnt_q >= C_BLANK);
        end
    endgenerate

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        active_d     = en;
        frame_tick_d = 1'b0;
        if (en) begin
            if (w_slot_end) begin
                cnt_d = '0;
                idx_d = (idx_q == C_IDX_LAST) ? 2'd0 : idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + C_CW'(1);
            end
            // Snapshot on the clock that opens a new frame, so a frame never mixes data.
            if (w_frame_end) begin
                shadow_d     = digits_in;
                frame_tick_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            shadow_q     <= '0;
            active_q     <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    always_comb begin
        s  = 4'd0;
        an = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == 2'(k)) begin
                s     = shadow_q[4*k +: 4];
                an[k] = ~(active_q && w_lit);
            end
        end
    end

    assign digit_idx  = idx_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_mux
// Purpose  : Directed, table-driven bench for hex_display_mux in a two-digit
//            blanked configuration and a four-digit unblanked configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_mux;

    logic        clk;
    logic        rst_a, en_a, ft_a;
    logic [7:0]  din_a;
    logic [3:0]  s_a;
    logic [1:0]  an_a, idx_a;
    logic        rst_b, en_b, ft_b;
    logic [15:0] din_b;
    logic [3:0]  s_b, an_b;
    logic [1:0]  idx_b;

    int n_checks = 0;
    int n_pass   = 0;
    int viol     = 0;
    logic ft_a_prev = 1'b0;
    logic ft_b_prev = 1'b0;

    hex_display_mux #(.NUM_DIGITS(2), .DIGIT_CYCLES(8), .BLANK_CYCLES(2)) u_a (
        .clk(clk), .reset(rst_a), .en(en_a), .digits_in(din_a),
        .s(s_a), .an(an_a), .digit_idx(idx_a), .frame_tick(ft_a)
    );

    hex_display_mux #(.NUM_DIGITS(4), .DIGIT_CYCLES(4), .BLANK_CYCLES(0)) u_b (
        .clk(clk), .reset(rst_b), .en(en_b), .digits_in(din_b),
        .s(s_b), .an(an_b), .digit_idx(idx_b), .frame_tick(ft_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // At most one anode low, and no back-to-back frame ticks, in either instance.
    always @(negedge clk) begin
        viol <= viol + (($countones(~an_a) > 1) ? 1 : 0) + (($countones(~an_b) > 1) ? 1 : 0)
                     + ((ft_a && ft_a_prev) ? 1 : 0) + ((ft_b && ft_b_prev) ? 1 : 0);
        ft_a_prev <= ft_a;
        ft_b_prev <= ft_b;
    end

    typedef struct {
        logic        en;
        logic [15:0] din;
        logic [3:0]  an;
        logic [3:0]  s;
        logic [1:0]  idx;
        logic        ft;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic en, input logic [15:0] din, input logic [3:0] an,
                                input logic [3:0] s, input logic [1:0] idx, input logic ft,
                                input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{en, din, an, s, idx, ft});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_vecs(input bit sel_b, input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            if (sel_b) begin
                en_b = vecs[i].en; din_b = vecs[i].din;
            end else begin
                en_a = vecs[i].en; din_a = vecs[i].din[7:0];
            end
            tick();
            if (sel_b) begin
                check($sformatf("%s[%0d].an",  tag, i), 32'(an_b),  32'(vecs[i].an));
                check($sformatf("%s[%0d].s",   tag, i), 32'(s_b),   32'(vecs[i].s));
                check($sformatf("%s[%0d].idx", tag, i), 32'(idx_b), 32'(vecs[i].idx));
                check($sformatf("%s[%0d].ft",  tag, i), 32'(ft_b),  32'(vecs[i].ft));
            end else begin
                check($sformatf("%s[%0d].an",  tag, i), 32'(an_a),  32'(vecs[i].an));
                check($sformatf("%s[%0d].s",   tag, i), 32'(s_a),   32'(vecs[i].s));
                check($sformatf("%s[%0d].idx", tag, i), 32'(idx_a), 32'(vecs[i].idx));
                check($sformatf("%s[%0d].ft",  tag, i), 32'(ft_a),  32'(vecs[i].ft));
            end
        end
        vecs.delete();
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b1; din_a = 8'hA5;
        rst_b = 1'b1; en_b = 1'b1; din_b = 16'h1234;
        tick();
        tick();
        check("rst_a.an",  32'(an_a),  32'h3);
        check("rst_a.s",   32'(s_a),   32'h0);
        check("rst_a.idx", 32'(idx_a), 32'h0);
        check("rst_a.ft",  32'(ft_a),  32'h0);
        check("rst_b.an",  32'(an_b),  32'hF);
        check("rst_b.s",   32'(s_b),   32'h0);
        rst_a = 1'b0;

        // Frame 1 shows zeros, frame 2 shows A5.
        add(1, 16'hA5, 4'h3, 4'h0, 2'd0, 1'b0, 1);
        add(1, 16'hA5, 4'h2, 4'h0, 2'd0, 1'b0, 6);
        add(1, 16'hA5, 4'h3, 4'h0, 2'd1, 1'b0, 2);
        add(1, 16'hA5, 4'h1, 4'h0, 2'd1, 1'b0, 6);
        add(1, 16'hA5, 4'h3, 4'h5, 2'd0, 1'b1, 1);
        add(1, 16'hA5, 4'h3, 4'h5, 2'd0, 1'b0, 1);
        add(1, 16'hA5, 4'h2, 4'h5, 2'd0, 1'b0, 6);
        add(1, 16'hA5, 4'h3, 4'hA, 2'd1, 1'b0, 2);
        add(1, 16'hA5, 4'h1, 4'hA, 2'd1, 1'b0, 6);
        add(1, 16'hA5, 4'h3, 4'h5, 2'd0, 1'b1, 1);
        // Mid-frame change to 3C stays invisible until the next frame.
        add(1, 16'hA5, 4'h3, 4'h5, 2'd0, 1'b0, 1);
        add(1, 16'h3C, 4'h2, 4'h5, 2'd0, 1'b0, 6);
        add(1, 16'h3C, 4'h3, 4'hA, 2'd1, 1'b0, 2);
        add(1, 16'h3C, 4'h1, 4'hA, 2'd1, 1'b0, 6);
        add(1, 16'h3C, 4'h3, 4'hC, 2'd0, 1'b1, 1);
        add(1, 16'h3C, 4'h3, 4'hC, 2'd0, 1'b0, 1);
        add(1, 16'h3C, 4'h2, 4'hC, 2'd0, 1'b0, 6);
        add(1, 16'h3C, 4'h3, 4'h3, 2'd1, 1'b0, 2);
        add(1, 16'h3C, 4'h1, 4'h3, 2'd1, 1'b0, 6);
        add(1, 16'h3C, 4'h3, 4'hC, 2'd0, 1'b1, 1);
        // Advance to cnt=4, idx=1, then gate for 10 cycles and resume at cnt=5.
        add(1, 16'h3C, 4'h3, 4'hC, 2'd0, 1'b0, 1);
        add(1, 16'h3C, 4'h2, 4'hC, 2'd0, 1'b0, 6);
        add(1, 16'h3C, 4'h3, 4'h3, 2'd1, 1'b0, 2);
        add(1, 16'h3C, 4'h1, 4'h3, 2'd1, 1'b0, 3);
        add(0, 16'h3C, 4'h3, 4'h3, 2'd1, 1'b0, 10);
        add(1, 16'h3C, 4'h1, 4'h3, 2'd1, 1'b0, 3);
        add(1, 16'h3C, 4'h3, 4'hC, 2'd0, 1'b1, 1);
        run_vecs(1'b0, "a");

        // Asynchronous reset between edges while digit 1 is lit.
        repeat (11) tick();
        check("pre_arst.an",  32'(an_a),  32'h1);
        check("pre_arst.idx", 32'(idx_a), 32'h1);
        #3 rst_a = 1'b1;
        #1;
        check("arst.an",  32'(an_a),  32'h3);
        check("arst.s",   32'(s_a),   32'h0);
        check("arst.idx", 32'(idx_a), 32'h0);
        check("arst.ft",  32'(ft_a),  32'h0);
        tick();
        check("arst_hold.an", 32'(an_a), 32'h3);
        rst_a = 1'b0;
        tick();
        check("post_arst1.an",  32'(an_a),  32'h3);
        check("post_arst1.idx", 32'(idx_a), 32'h0);
        tick();
        check("post_arst2.an", 32'(an_a), 32'h2);
        check("post_arst2.s",  32'(s_a),  32'h0);

        // Four digits, no blanking.
        rst_b = 1'b0;
        add(1, 16'h1234, 4'hE, 4'h0, 2'd0, 1'b0, 3);
        add(1, 16'h1234, 4'hD, 4'h0, 2'd1, 1'b0, 4);
        add(1, 16'h1234, 4'hB, 4'h0, 2'd2, 1'b0, 4);
        add(1, 16'h1234, 4'h7, 4'h0, 2'd3, 1'b0, 4);
        add(1, 16'h1234, 4'hE, 4'h4, 2'd0, 1'b1, 1);
        add(1, 16'h1234, 4'hE, 4'h4, 2'd0, 1'b0, 3);
        add(1, 16'h1234, 4'hD, 4'h3, 2'd1, 1'b0, 4);
        add(1, 16'h1234, 4'hB, 4'h2, 2'd2, 1'b0, 4);
        add(1, 16'h1234, 4'h7, 4'h1, 2'd3, 1'b0, 4);
        add(1, 16'h1234, 4'hE, 4'h4, 2'd0, 1'b1, 1);
        run_vecs(1'b1, "b");

        tick();
        check("onehot_monitor", 32'(viol), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
